// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one synchronous single-port memory between the
// instruction-fetch port and the load/store port. Each transaction takes a
// fixed four-state walk (IDLE, ISSUE, CAPTURE, RESP), so the memory bus is
// driven from registers only and every requester sees a one-cycle ack with
// registered read data. Data accesses win ties unless a fetch has already
// lost MAX_WAIT arbitrations in a row.
module core_mem_arbiter #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic                  if_ack_o,
   output logic [DATA_WIDTH-1:0] if_rdata_o,
   input  logic                  dm_req_i,
   input  logic                  dm_we_i,
   input  logic [ADDR_WIDTH-1:0] dm_addr_i,
   input  logic [DATA_WIDTH-1:0] dm_wdata_i,
   output logic                  dm_ack_o,
   output logic [DATA_WIDTH-1:0] dm_rdata_o,
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  busy_o
);

   // The counter must be able to hold MAX_WAIT itself; a zero limit still
   // gets a one-bit counter that simply never leaves zero.
   localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      RESP
   } state_t;

   state_t         state;
   logic           owner_dm;
   logic           op_we;
   logic [WCW-1:0] wait_cnt;
   logic           dm_wins;
   logic           if_wins;

   // Arbitration: data wins unless a fetch is also waiting and has already
   // been passed over MAX_WAIT times in a row.
   always_comb begin
      dm_wins = 1'b0;
      if_wins = 1'b0;
      dm_wins = dm_req_i && (!if_req_i || (wait_cnt < WAIT_LIMIT));
      if_wins = if_req_i && !dm_wins;
   end

   // The core has no other stall source, so busy is just "not idle".
   assign busy_o = (state != IDLE);

   // Transaction sequencer: grants in IDLE, holds the memory enable for one
   // cycle, captures read data the cycle after, then pulses the owner's ack.
   // op_we remembers a store so CAPTURE leaves the load data register alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         owner_dm    <= 1'b0;
         op_we       <= 1'b0;
         wait_cnt    <= '0;
         mem_en_o    <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         if_ack_o    <= 1'b0;
         dm_ack_o    <= 1'b0;
         if_rdata_o  <= '0;
         dm_rdata_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (dm_wins) begin
                  state       <= ISSUE;
                  owner_dm    <= 1'b1;
                  op_we       <= dm_we_i;
                  mem_en_o    <= 1'b1;
                  mem_we_o    <= dm_we_i;
                  mem_addr_o  <= dm_addr_i;
                  mem_wdata_o <= dm_wdata_i;
                  if (if_req_i && (wait_cnt != WAIT_LIMIT)) begin
                     wait_cnt <= wait_cnt + WCW'(1);
                  end
               end else if (if_wins) begin
                  state       <= ISSUE;
                  owner_dm    <= 1'b0;
                  op_we       <= 1'b0;
                  mem_en_o    <= 1'b1;
                  mem_we_o    <= 1'b0;
                  mem_addr_o  <= if_addr_i;
                  mem_wdata_o <= '0;
                  wait_cnt    <= '0;
               end
            end
            ISSUE: begin
               state    <= CAPTURE;
               mem_en_o <= 1'b0;
               mem_we_o <= 1'b0;
            end
            CAPTURE: begin
               state <= RESP;
               if (owner_dm) begin
                  dm_ack_o <= 1'b1;
                  if (!op_we) begin
                     dm_rdata_o <= mem_rdata_i;
                  end
               end else begin
                  if_ack_o   <= 1'b1;
                  if_rdata_o <= mem_rdata_i;
               end
            end
            RESP: begin
               state    <= IDLE;
               if_ack_o <= 1'b0;
               dm_ack_o <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed bench for core_mem_arbiter. A scoreboard
// queue holds the expected ack owner and read data for each transaction
// issued; a negedge monitor pops and compares on every ack. A second
// instance with MAX_WAIT=0 covers the fetch-first tie rule.
module tb_core_mem_arbiter;

   typedef struct packed {
      logic        isDm;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        rst;

   logic        if_req, if_ack, dm_req, dm_we, dm_ack, mem_en, mem_we, busy;
   logic [9:0]  if_addr, dm_addr, mem_addr;
   logic [31:0] if_rdata, dm_rdata, dm_wdata, mem_wdata, mem_rdata;

   logic        if_req0, if_ack0, dm_req0, dm_we0, dm_ack0, mem_en0, mem_we0, busy0;
   logic [9:0]  if_addr0, dm_addr0, mem_addr0;
   logic [31:0] if_rdata0, dm_rdata0, dm_wdata0, mem_wdata0, mem_rdata0;

   logic [31:0] mem     [1024];
   logic        written [1024];
   logic [31:0] shadow  [1024];

   exp_t        sbQ[$];
   logic [31:0] lastDm;
   logic [31:0] lastIf;
   int          total;
   int          bad;

   core_mem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MAX_WAIT(2)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
      .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
      .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .busy_o(busy)
   );

   core_mem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MAX_WAIT(0)) dut0 (
      .clk(clk), .rst(rst),
      .if_req_i(if_req0), .if_addr_i(if_addr0), .if_ack_o(if_ack0), .if_rdata_o(if_rdata0),
      .dm_req_i(dm_req0), .dm_we_i(dm_we0), .dm_addr_i(dm_addr0), .dm_wdata_i(dm_wdata0),
      .dm_ack_o(dm_ack0), .dm_rdata_o(dm_rdata0),
      .mem_en_o(mem_en0), .mem_we_o(mem_we0), .mem_addr_o(mem_addr0), .mem_wdata_o(mem_wdata0),
      .mem_rdata_i(mem_rdata0), .busy_o(busy0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] initWord(input logic [9:0] a);
      if (a == 10'h004) return 32'h00500093;
      return 32'hC0DE0000 | 32'(a);
   endfunction

   // Memory model for the main instance: registered read, valid only in the
   // cycle after a read enable, garbage otherwise.
   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         mem[mem_addr]     <= mem_wdata;
         written[mem_addr] <= 1'b1;
         mem_rdata         <= 32'hBAD0BAD0;
      end else if (mem_en) begin
         mem_rdata <= (written[mem_addr] === 1'b1) ? mem[mem_addr] : initWord(mem_addr);
      end else begin
         mem_rdata <= 32'hBAD0BAD0;
      end
   end

   // Read-only memory model for the MAX_WAIT=0 instance.
   always @(posedge clk) begin
      mem_rdata0 <= mem_en0 ? (32'h77000000 | 32'(mem_addr0)) : 32'hBAD0BAD0;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic pushExp(input logic isDm, input logic we, input logic [9:0] addr,
                          input logic [31:0] wdata);
      exp_t e;
      e.isDm = isDm;
      if (isDm && we) begin
         shadow[addr] = wdata;
         e.data = lastDm;
      end else if (isDm) begin
         lastDm = shadow[addr];
         e.data = lastDm;
      end else begin
         lastIf = shadow[addr];
         e.data = lastIf;
      end
      sbQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic isDm, input logic we, input logic [9:0] addr,
                                input logic [31:0] wdata);
      pushExp(isDm, we, addr, wdata);
      if (isDm) begin
         dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
   endtask

   task automatic waitAck(input logic wantDm, output int cycles);
      logic found;
      found  = 1'b0;
      cycles = 0;
      while (!found && cycles < 20) begin
         @(negedge clk);
         if (wantDm ? dm_ack : if_ack) found = 1'b1;
         else cycles++;
      end
      if (!found) checkOutput("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic waitAny(output logic gotDm);
      logic found;
      found = 1'b0;
      gotDm = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (if_ack || dm_ack) begin
            found = 1'b1;
            gotDm = dm_ack;
         end
      end
      if (!found) checkOutput("any_ack_timeout", 32'd0, 32'd1);
   endtask

   // Scoreboard monitor for the main instance.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (if_ack || dm_ack)) begin
         checkOutput("ack_exclusive", 32'(if_ack & dm_ack), 32'd0);
         if (sbQ.size() == 0) begin
            checkOutput("unexpected_ack", 32'd1, 32'd0);
         end else begin
            e = sbQ.pop_front();
            checkOutput("ack_port", 32'(dm_ack), 32'(e.isDm));
            checkOutput("ack_rdata", e.isDm ? dm_rdata : if_rdata, e.data);
         end
      end
   end

   initial begin
      int          cyc;
      logic        gotDm;
      logic [7:0]  busyPat;
      logic [7:0]  ackPat;
      logic [5:0]  orderPat;
      logic        found;

      total = 0; bad = 0; lastDm = '0; lastIf = '0;
      for (int i = 0; i < 1024; i++) shadow[i] = initWord(10'(i));
      rst = 1'b1;
      if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
      if_req0 = 0; if_addr0 = '0; dm_req0 = 0; dm_we0 = 0; dm_addr0 = '0; dm_wdata0 = '0;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
      checkOutput("rst_acks", 32'({if_ack, dm_ack}), 32'd0);
      checkOutput("rst_if_rdata", if_rdata, 32'd0);
      checkOutput("rst_dm_rdata", dm_rdata, 32'd0);
      rst = 1'b0;

      // Single fetch
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 10'h004, 32'd0);
      @(negedge clk);
      checkOutput("fetch_idle_busy", 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput("fetch_mem_en", 32'(mem_en), 32'd1);
      checkOutput("fetch_mem_addr", 32'(mem_addr), 32'h004);
      checkOutput("fetch_mem_we", 32'(mem_we), 32'd0);
      checkOutput("fetch_busy", 32'(busy), 32'd1);
      @(negedge clk);
      checkOutput("fetch_mem_en_drop", 32'(mem_en), 32'd0);
      @(negedge clk);
      checkOutput("fetch_ack", 32'(if_ack), 32'd1);
      checkOutput("fetch_rdata", if_rdata, 32'h00500093);
      if_req = 1'b0;

      // Store then load
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b1, 10'h010, 32'hDEADBEEF);
      @(negedge clk);
      @(negedge clk);
      checkOutput("store_mem_we", 32'(mem_we), 32'd1);
      checkOutput("store_mem_wdata", mem_wdata, 32'hDEADBEEF);
      checkOutput("store_mem_addr", 32'(mem_addr), 32'h010);
      @(negedge clk);
      checkOutput("store_mem_we_drop", 32'(mem_we), 32'd0);
      @(negedge clk);
      checkOutput("store_ack", 32'(dm_ack), 32'd1);
      checkOutput("store_rdata_held", dm_rdata, 32'd0);
      dm_req = 1'b0;
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b0, 10'h010, 32'd0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("load_mem_we", 32'(mem_we), 32'd0);
      waitAck(1'b1, cyc);
      checkOutput("load_latency", 32'(cyc), 32'd1);
      checkOutput("load_rdata", dm_rdata, 32'hDEADBEEF);
      dm_req = 1'b0;

      // Fetch request held across two transactions
      busyPat = 8'hEE;
      ackPat  = 8'h88;
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 10'h040, 32'd0);
      pushExp(1'b0, 1'b0, 10'h040, 32'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checkOutput("held_busy", 32'(busy), 32'(busyPat[i]));
         checkOutput("held_ack", 32'(if_ack), 32'(ackPat[i]));
         if (i == 7) if_req = 1'b0;
      end

      // Contention with MAX_WAIT=2: DM, DM, IF, DM, DM, IF
      orderPat = 6'b011011;
      for (int k = 0; k < 6; k++) begin
         if (orderPat[k]) pushExp(1'b1, 1'b0, 10'h030, 32'd0);
         else pushExp(1'b0, 1'b0, 10'h020, 32'd0);
      end
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 10'h020;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h030; dm_wdata = 32'd0;
      for (int k = 0; k < 6; k++) begin
         waitAny(gotDm);
         checkOutput("grant_order", 32'(gotDm), 32'(orderPat[k]));
         if (k == 5) begin
            if_req = 1'b0;
            dm_req = 1'b0;
         end else begin
            if (gotDm) dm_req = 1'b0; else if_req = 1'b0;
            @(posedge clk); #1;
            if (gotDm) dm_req = 1'b1; else if_req = 1'b1;
         end
      end

      // MAX_WAIT=0 instance: simultaneous requests, fetch first
      @(posedge clk); #1;
      if_req0 = 1'b1; if_addr0 = 10'h055;
      dm_req0 = 1'b1; dm_we0 = 1'b0; dm_addr0 = 10'h066;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (if_ack0 || dm_ack0) found = 1'b1;
      end
      checkOutput("mw0_first_found", 32'(found), 32'd1);
      checkOutput("mw0_first_is_if", 32'({if_ack0, dm_ack0}), 32'b10);
      checkOutput("mw0_if_rdata", if_rdata0, 32'h77000055);
      if_req0 = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (if_ack0 || dm_ack0) found = 1'b1;
      end
      checkOutput("mw0_second_found", 32'(found), 32'd1);
      checkOutput("mw0_second_is_dm", 32'({if_ack0, dm_ack0}), 32'b01);
      checkOutput("mw0_dm_rdata", dm_rdata0, 32'h77000066);
      dm_req0 = 1'b0;

      // Reset during CAPTURE of a load
      @(posedge clk); #1;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h030; dm_wdata = 32'h12345678;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_mem_en_we", 32'({mem_en, mem_we}), 32'd0);
      checkOutput("midrst_mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("midrst_mem_wdata", mem_wdata, 32'd0);
      checkOutput("midrst_acks", 32'({if_ack, dm_ack}), 32'd0);
      checkOutput("midrst_if_rdata", if_rdata, 32'd0);
      checkOutput("midrst_dm_rdata", dm_rdata, 32'd0);
      dm_req = 1'b0;
      @(negedge clk);
      checkOutput("midrst_no_ack", 32'(dm_ack), 32'd0);
      rst = 1'b0;
      lastDm = '0;
      lastIf = '0;
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b0, 10'h010, 32'd0);
      waitAck(1'b1, cyc);
      checkOutput("post_rst_latency", 32'(cyc), 32'd3);
      checkOutput("post_rst_rdata", dm_rdata, 32'hDEADBEEF);
      dm_req = 1'b0;

      repeat (4) @(negedge clk);
      checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
